// File: rtl/alu_result_stage_pkg.sv
// alu_pkg: shared types for the ALU result/writeback stage.
//   op_e          - 4-bit opcode encoding (11..15 are illegal)
//   FLAG_*        - bit positions inside the {N, Z, C} flag vector
//   stage_entry_t - one buffered payload {result, rd, we, illegal, flags}
//   skid_state_e  - occupancy of the two-entry skid buffer
// The entry struct is sized by ALU_N / ALU_RD_W; the stage's N and RD_W
// parameters default to these and must match them.
package alu_pkg;

    localparam int ALU_N    = 4;
    localparam int ALU_RD_W = 4;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_CMP = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_MUL = 4'd4,
        OP_DIV = 4'd5,
        OP_XOR = 4'd6,
        OP_AND = 4'd7,
        OP_NOT = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    typedef struct packed {
        logic [ALU_N-1:0]    result;
        logic [ALU_RD_W-1:0] rd;
        logic                we;
        logic                illegal;
        logic [2:0]          flags;
    } stage_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: bundles the upstream (Operator side) and downstream
// (register-file side) handshakes of the result stage.
//   in_valid/in_ready, in_op, in_rd, r_* (eleven N+1-bit candidate results)
//   out_valid/out_ready, out_result, out_rd, out_we, out_illegal, out_flags
// Modports: slave  = the stage itself
//           master = whoever drives the inputs and consumes the outputs
interface alu_result_stage_if #(
    parameter int N    = 4,
    parameter int RD_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [RD_W-1:0] in_rd;
    logic [N:0]      r_mov, r_compare, r_add, r_sub, r_mul, r_div;
    logic [N:0]      r_xor, r_and, r_not, r_shl, r_shr;

    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_we;
    logic            out_illegal;
    logic [2:0]      out_flags;

    modport slave (
        input  in_valid, in_op, in_rd,
        input  r_mov, r_compare, r_add, r_sub, r_mul, r_div,
        input  r_xor, r_and, r_not, r_shl, r_shr,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_rd, out_we, out_illegal, out_flags
    );

    modport master (
        output in_valid, in_op, in_rd,
        output r_mov, r_compare, r_add, r_sub, r_mul, r_div,
        output r_xor, r_and, r_not, r_shl, r_shr,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_rd, out_we, out_illegal, out_flags
    );
endinterface

// File: rtl/alu_result_select.sv
// alu_result_select: combinational opcode-driven pick of one of the eleven
// Operator results, packed into a stage_entry_t together with rd, write
// enable, illegal marker and (optionally) {N, Z, C} flags.
//   op, rd       - instruction opcode and destination register
//   r_*          - N+1-bit candidate results
//   entry        - payload ready to be registered
// Build option: ALU_STAGE_FLAGS_EN builds the flag logic; otherwise the
// flags field stays zero.
module alu_result_select
    import alu_pkg::*;
#(
    parameter int N    = ALU_N,
    parameter int RD_W = ALU_RD_W
) (
    input  logic [3:0]      op,
    input  logic [RD_W-1:0] rd,
    input  logic [N:0]      r_mov,
    input  logic [N:0]      r_compare,
    input  logic [N:0]      r_add,
    input  logic [N:0]      r_sub,
    input  logic [N:0]      r_mul,
    input  logic [N:0]      r_div,
    input  logic [N:0]      r_xor,
    input  logic [N:0]      r_and,
    input  logic [N:0]      r_not,
    input  logic [N:0]      r_shl,
    input  logic [N:0]      r_shr,
    output stage_entry_t    entry
);

    logic [N:0] sel;
    logic       legal;
    logic       carry_op;

    // carry_op marks the opcodes whose bit N is a meaningful carry/borrow
    always_comb begin
        sel      = '0;
        legal    = 1'b1;
        carry_op = 1'b0;
        case (op)
            OP_MOV: sel = r_mov;
            OP_CMP: begin sel = r_compare; carry_op = 1'b1; end
            OP_ADD: begin sel = r_add;     carry_op = 1'b1; end
            OP_SUB: begin sel = r_sub;     carry_op = 1'b1; end
            OP_MUL: begin sel = r_mul;     carry_op = 1'b1; end
            OP_DIV: sel = r_div;
            OP_XOR: sel = r_xor;
            OP_AND: sel = r_and;
            OP_NOT: sel = r_not;
            OP_SHL: begin sel = r_shl;     carry_op = 1'b1; end
            OP_SHR: sel = r_shr;
            default: legal = 1'b0;
        endcase
    end

    // Illegal opcodes still produce an entry so they occupy a slot downstream
    always_comb begin
        entry         = '0;
        entry.rd      = rd;
        entry.illegal = !legal;
        if (legal) begin
            entry.result = sel[N-1:0];
            entry.we     = (op != OP_CMP);
`ifdef ALU_STAGE_FLAGS_EN
            entry.flags[FLAG_Z] = (sel[N-1:0] == '0);
            entry.flags[FLAG_N] = sel[N-1];
            entry.flags[FLAG_C] = carry_op & sel[N];
`endif
        end
    end

`ifndef ALU_STAGE_FLAGS_EN
    logic carry_unused;
    assign carry_unused = sel[N] ^ carry_op;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result-select/writeback stage behind Operator.
// Picks the opcode's result, derives flags, and holds payloads in a two-entry
// skid buffer (head drives out_*, skid catches one extra entry) so that
// in_ready depends only on registered state.
//   clk, rst  - clock; asynchronous active-high reset
//   bus       - alu_result_stage_if.slave (in_* / r_* / out_* handshakes)
// Build option: ALU_STAGE_FLAGS_EN stores flags per entry and drives
// out_flags; without it out_flags is tied to 3'b000.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N    = ALU_N,
    parameter int RD_W = ALU_RD_W
) (
    input logic               clk,
    input logic               rst,
    alu_result_stage_if.slave bus
);

    skid_state_e  state_q, state_d;
    stage_entry_t in_entry, head_q, skid_q;
    logic         in_fire, out_fire;
    logic         load_head_in, load_head_skid, load_skid;
    logic         in_ready_int, out_valid_int;

    alu_result_select #(.N(N), .RD_W(RD_W)) u_select (
        .op        (bus.in_op),
        .rd        (bus.in_rd),
        .r_mov     (bus.r_mov),
        .r_compare (bus.r_compare),
        .r_add     (bus.r_add),
        .r_sub     (bus.r_sub),
        .r_mul     (bus.r_mul),
        .r_div     (bus.r_div),
        .r_xor     (bus.r_xor),
        .r_and     (bus.r_and),
        .r_not     (bus.r_not),
        .r_shl     (bus.r_shl),
        .r_shr     (bus.r_shr),
        .entry     (in_entry)
    );

    assign in_fire  = bus.in_valid && in_ready_int;
    assign out_fire = out_valid_int && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next state plus the register-load steering that goes with each move
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d      = ST_ONE;
                    load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_head_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d        = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs come from registered state only
    always_comb begin
        in_ready_int  = (state_q != ST_FULL);
        out_valid_int = (state_q != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in)        head_q <= in_entry;
            else if (load_head_skid) head_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = out_valid_int;
    assign bus.out_result  = head_q.result;
    assign bus.out_rd      = head_q.rd;
    assign bus.out_we      = head_q.we;
    assign bus.out_illegal = head_q.illegal;

`ifdef ALU_STAGE_FLAGS_EN
    assign bus.out_flags = head_q.flags;
`else
    logic [2:0] flags_unused;
    assign flags_unused  = head_q.flags;
    assign bus.out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: self-checking bench for alu_result_stage (N=4, RD_W=4).
// Directed vector table, hand-written stall and reset sequences, then a
// randomized run compared against a FIFO-of-payloads reference model.
// Expected flags honour the ALU_STAGE_FLAGS_EN build option.
module tb_alu_result_stage;

    typedef struct packed {
        logic [3:0] result;
        logic [3:0] rd;
        logic       we;
        logic       illegal;
        logic [2:0] flags;
    } exp_t;

    typedef struct {
        int         op;
        logic [3:0] rd;
        logic [4:0] val;
        exp_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [4:0] bus_val [11];
    vec_t       vecs[$];
    exp_t       model_q[$];

    alu_result_stage_if #(.N(4), .RD_W(4)) bus_if ();

    alu_result_stage #(.N(4), .RD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] flagsIfBuilt(logic [2:0] f);
`ifdef ALU_STAGE_FLAGS_EN
        return f;
`else
        return f & 3'b000;
`endif
    endfunction

    function automatic exp_t mkExp(logic [3:0] result, logic [3:0] rd, logic we,
                                   logic ill, logic [2:0] flags);
        exp_t e;
        e.result  = result;
        e.rd      = rd;
        e.we      = we;
        e.illegal = ill;
        e.flags   = flagsIfBuilt(flags);
        return e;
    endfunction

    // Reference: value = chosen bus as an integer; flags by arithmetic
    function automatic exp_t modelEntry(int op, logic [3:0] rd, logic [4:0] vals [11]);
        exp_t       e;
        int         v;
        logic [2:0] f;
        e    = '0;
        e.rd = rd;
        if (op >= 11) begin
            e.illegal = 1'b1;
            return e;
        end
        v        = int'(vals[op]);
        e.result = 4'(v % 16);
        e.we     = (op != 1);
        f[2]     = ((v / 8) % 2) == 1;
        f[1]     = (v % 16) == 0;
        f[0]     = (op inside {1, 2, 3, 4, 9}) && (v >= 16);
        e.flags  = flagsIfBuilt(f);
        return e;
    endfunction

    task automatic fillBuses(int sel, logic [4:0] v);
        for (int i = 0; i < 11; i++)
            bus_val[i] = (i == sel) ? v : (v ^ 5'((i + 1) * 3));
    endtask

    task automatic applyStimulus(logic valid, int op, logic [3:0] rd, logic ready);
        bus_if.in_valid  = valid;
        bus_if.in_op     = 4'(op);
        bus_if.in_rd     = rd;
        bus_if.out_ready = ready;
        bus_if.r_mov     = bus_val[0];
        bus_if.r_compare = bus_val[1];
        bus_if.r_add     = bus_val[2];
        bus_if.r_sub     = bus_val[3];
        bus_if.r_mul     = bus_val[4];
        bus_if.r_div     = bus_val[5];
        bus_if.r_xor     = bus_val[6];
        bus_if.r_and     = bus_val[7];
        bus_if.r_not     = bus_val[8];
        bus_if.r_shl     = bus_val[9];
        bus_if.r_shr     = bus_val[10];
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name, exp_t e);
        checkVal({name, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        checkVal({name, "_payload"},
                 32'({bus_if.out_result, bus_if.out_rd, bus_if.out_we,
                      bus_if.out_illegal, bus_if.out_flags}),
                 32'(e));
    endtask

    initial begin
        exp_t e;
        int   op;
        logic v, r, in_f, out_f;

        checks   = 0;
        failures = 0;
        fillBuses(-1, 5'd0);
        applyStimulus(1'b0, 0, 4'd0, 1'b0);
        rst = 1'b1;
        repeat (2) stepCycle();

        // Reset values, during and right after reset
        checkVal("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkVal("reset_in_ready",  32'(bus_if.in_ready),  32'd1);
        checkVal("reset_payload",
                 32'({bus_if.out_result, bus_if.out_rd, bus_if.out_we,
                      bus_if.out_illegal, bus_if.out_flags}), 32'd0);
        rst = 1'b0;
        stepCycle();
        checkVal("idle_out_valid", 32'(bus_if.out_valid), 32'd0);

        // Directed table: {op, rd, selected bus} -> {result, rd, we, illegal, {N,Z,C}}
        vecs.push_back('{2,  4'd3,  5'b00110, mkExp(4'd6,  4'd3,  1'b1, 1'b0, 3'b000)});
        vecs.push_back('{3,  4'd5,  5'b11110, mkExp(4'd14, 4'd5,  1'b1, 1'b0, 3'b101)});
        vecs.push_back('{1,  4'd7,  5'b00000, mkExp(4'd0,  4'd7,  1'b0, 1'b0, 3'b010)});
        vecs.push_back('{12, 4'd2,  5'b11111, mkExp(4'd0,  4'd2,  1'b0, 1'b1, 3'b000)});
        vecs.push_back('{4,  4'd1,  5'b10011, mkExp(4'd3,  4'd1,  1'b1, 1'b0, 3'b001)});
        vecs.push_back('{5,  4'd4,  5'b11000, mkExp(4'd8,  4'd4,  1'b1, 1'b0, 3'b100)});
        vecs.push_back('{10, 4'd6,  5'b10000, mkExp(4'd0,  4'd6,  1'b1, 1'b0, 3'b010)});
        vecs.push_back('{9,  4'd8,  5'b10000, mkExp(4'd0,  4'd8,  1'b1, 1'b0, 3'b011)});
        vecs.push_back('{8,  4'd9,  5'b01010, mkExp(4'd10, 4'd9,  1'b1, 1'b0, 3'b100)});
        vecs.push_back('{0,  4'd10, 5'b10111, mkExp(4'd7,  4'd10, 1'b1, 1'b0, 3'b000)});
        vecs.push_back('{15, 4'd11, 5'b01100, mkExp(4'd0,  4'd11, 1'b0, 1'b1, 3'b000)});
        vecs.push_back('{7,  4'd12, 5'b00001, mkExp(4'd1,  4'd12, 1'b1, 1'b0, 3'b000)});
        vecs.push_back('{6,  4'd13, 5'b11111, mkExp(4'd15, 4'd13, 1'b1, 1'b0, 3'b100)});

        foreach (vecs[i]) begin
            fillBuses(vecs[i].op, vecs[i].val);
            applyStimulus(1'b1, vecs[i].op, vecs[i].rd, 1'b1);
            stepCycle();
            applyStimulus(1'b0, 0, 4'd0, 1'b1);
            checkOutput($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].exp);
        end
        stepCycle();
        checkVal("table_drained", 32'(bus_if.out_valid), 32'd0);

        // Stalled downstream: MOV, XOR accepted, AND held, then drained in order
        fillBuses(0, 5'b00101);
        applyStimulus(1'b1, 0, 4'd1, 1'b0);
        stepCycle();
        checkVal("stall_in_ready_one", 32'(bus_if.in_ready), 32'd1);
        checkOutput("stall_head_mov", mkExp(4'd5, 4'd1, 1'b1, 1'b0, 3'b000));
        fillBuses(6, 5'b01001);
        applyStimulus(1'b1, 6, 4'd2, 1'b0);
        stepCycle();
        checkVal("stall_in_ready_full", 32'(bus_if.in_ready), 32'd0);
        checkOutput("stall_head_mov2", mkExp(4'd5, 4'd1, 1'b1, 1'b0, 3'b000));
        fillBuses(7, 5'b10000);
        applyStimulus(1'b1, 7, 4'd3, 1'b0);
        stepCycle();
        checkVal("stall_and_held", 32'(bus_if.in_ready), 32'd0);
        checkOutput("stall_head_stable", mkExp(4'd5, 4'd1, 1'b1, 1'b0, 3'b000));
        bus_if.out_ready = 1'b1;
        stepCycle();
        checkOutput("drain_xor", mkExp(4'd9, 4'd2, 1'b1, 1'b0, 3'b100));
        checkVal("drain_in_ready", 32'(bus_if.in_ready), 32'd1);
        stepCycle();
        checkOutput("drain_and", mkExp(4'd0, 4'd3, 1'b1, 1'b0, 3'b010));
        applyStimulus(1'b0, 0, 4'd0, 1'b1);
        stepCycle();
        checkVal("drain_empty", 32'(bus_if.out_valid), 32'd0);

        // Randomized traffic against the payload-FIFO model
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            checkVal("rand_out_valid", 32'(bus_if.out_valid), 32'(model_q.size() > 0));
            checkVal("rand_in_ready",  32'(bus_if.in_ready),  32'(model_q.size() < 2));
            if (model_q.size() > 0)
                checkOutput($sformatf("rand_head_c%0d", cyc), model_q[0]);
            for (int i = 0; i < 11; i++) bus_val[i] = 5'($urandom);
            op = int'($urandom_range(0, 15));
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            applyStimulus(v, op, 4'($urandom), r);
            e     = modelEntry(op, bus_if.in_rd, bus_val);
            in_f  = v && (model_q.size() < 2);
            out_f = (model_q.size() > 0) && r;
            stepCycle();
            if (out_f) void'(model_q.pop_front());
            if (in_f)  model_q.push_back(e);
        end
        applyStimulus(1'b0, 0, 4'd0, 1'b1);
        repeat (3) stepCycle();
        checkVal("rand_drained", 32'(bus_if.out_valid), 32'd0);

        // Reset while FULL: entries vanish immediately, nothing emitted after
        fillBuses(0, 5'b00101);
        applyStimulus(1'b1, 0, 4'd1, 1'b0);
        stepCycle();
        fillBuses(6, 5'b01001);
        applyStimulus(1'b1, 6, 4'd2, 1'b0);
        stepCycle();
        checkVal("rst_pre_full", 32'(bus_if.in_ready), 32'd0);
        applyStimulus(1'b0, 0, 4'd0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkVal("rst_async_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkVal("rst_async_in_ready",  32'(bus_if.in_ready),  32'd1);
        checkVal("rst_async_payload",
                 32'({bus_if.out_result, bus_if.out_rd, bus_if.out_we,
                      bus_if.out_illegal, bus_if.out_flags}), 32'd0);
        stepCycle();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkVal("rst_post_quiet", 32'(bus_if.out_valid), 32'd0);
        end
        fillBuses(2, 5'b01111);
        applyStimulus(1'b1, 2, 4'd9, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 0, 4'd0, 1'b1);
        checkOutput("rst_first_accept", mkExp(4'd15, 4'd9, 1'b1, 1'b0, 3'b100));
        stepCycle();
        checkVal("rst_final_empty", 32'(bus_if.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
